// File: rtl/mm_reg_initiator_pkg.sv
// Shared types for the memory-mapped register initiator.
// Size encodings, FSM states and counter sizing helper.
package mm_reg_initiator_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERR   = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  localparam int LANES = 4;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic bad_req(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (size_e'(size))
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = |off;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mm_lane_align.sv
// Byte-lane steering: SEL, replicated write data, read extract.
// Ports: off/size/uns in, wdata/bus_rdata in, sel/wdat/rdata out.
module mm_lane_align
  import mm_reg_initiator_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = bus_rdata[7:0];
    unique case (off)
      2'd0: b = bus_rdata[7:0];
      2'd1: b = bus_rdata[15:8];
      2'd2: b = bus_rdata[23:16];
      2'd3: b = bus_rdata[31:24];
      default: b = bus_rdata[7:0];
    endcase
    h = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    sel   = '0;
    wdat  = '0;
    rdata = '0;
    unique case (size_e'(size))
      SIZE_BYTE: begin
        sel   = 4'b0001 << off;
        wdat  = {4{wdata[7:0]}};
        rdata = {{24{~uns & b[7]}}, b};
      end
      SIZE_HALF: begin
        sel   = 4'b0011 << off;
        wdat  = {2{wdata[15:0]}};
        rdata = {{16{~uns & h[15]}}, h};
      end
      SIZE_WORD: begin
        sel   = 4'hF;
        wdat  = wdata;
        rdata = bus_rdata;
      end
      default: begin
        sel   = '0;
        wdat  = '0;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/mm_reg_initiator.sv
// Wishbone initiator for the peripheral register space.
// Ports: core req/resp handshake, split WB read and write channels.
module mm_reg_initiator
  import mm_reg_initiator_pkg::*;
#(
  parameter int ADDR_BITS      = 16,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 resp_valid,
  output logic                 resp_error,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 WB_RD_STB_O,
  output logic [ADDR_BITS-1:0] WB_RD_ADR_O,
  input  logic [XLEN-1:0]      WB_RD_DAT_I,
  input  logic                 WB_RD_ACK_I,
  output logic                 WB_WR_STB_O,
  output logic                 WB_WR_WE_O,
  output logic [3:0]           WB_WR_SEL_O,
  output logic [ADDR_BITS-1:0] WB_WR_ADR_O,
  output logic [XLEN-1:0]      WB_WR_DAT_O,
  input  logic                 WB_WR_ACK_I
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  state_e state, state_n;

  logic [ADDR_BITS-1:0] adr_q;
  logic [1:0]           off_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 we_q;
  logic [XLEN-1:0]      wdata_q;
  logic [CW-1:0]        cnt_q;
  logic                 resp_v_q;
  logic                 resp_e_q;
  logic [XLEN-1:0]      rdata_q;

  logic            accept;
  logic            bad;
  logic            ack;
  logic            done;
  logic            tmo;
  logic            wr_issue;
  logic [3:0]      sel;
  logic [XLEN-1:0] wdat;
  logic [XLEN-1:0] rd_ext;
  logic            unused_addr;

  assign unused_addr = ^req_addr[XLEN-1:ADDR_BITS+2];

  assign accept = req_valid & req_ready;
  assign bad    = bad_req(req_size, req_addr[1:0]);

  // Only the channel matching the latched direction can finish.
  assign ack  = we_q ? WB_WR_ACK_I : WB_RD_ACK_I;
  assign done = ack & ((state == S_ISSUE) | (state == S_WAIT));
  assign tmo  = (state == S_WAIT) & ~ack & (cnt_q == TMAX);

  mm_lane_align u_align (
    .off       (off_q),
    .size      (size_q),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .bus_rdata (WB_RD_DAT_I),
    .sel       (sel),
    .wdat      (wdat),
    .rdata     (rd_ext)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    WB_RD_STB_O = 1'b0;
    WB_WR_STB_O = 1'b0;
    WB_WR_WE_O  = 1'b0;
    wr_issue    = 1'b0;
    resp_valid  = resp_v_q;
    resp_error  = resp_e_q;
    unique case (state)
      S_IDLE: begin
        req_ready = ~sync_reset;
        if (accept) state_n = bad ? S_ERR : S_ISSUE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
        state_n    = S_IDLE;
      end
      S_ISSUE: begin
        WB_RD_STB_O = ~we_q;
        WB_WR_STB_O = we_q;
        WB_WR_WE_O  = we_q;
        wr_issue    = we_q;
        state_n     = ack ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (ack | tmo) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign WB_RD_ADR_O = adr_q;
  assign WB_WR_ADR_O = adr_q;
  assign WB_WR_SEL_O = wr_issue ? sel : 4'h0;
  assign WB_WR_DAT_O = wr_issue ? wdat : '0;
  assign resp_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      adr_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      resp_v_q <= 1'b0;
      resp_e_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (accept & ~bad) begin
        adr_q   <= req_addr[ADDR_BITS+1:2];
        off_q   <= req_addr[1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if ((state == S_WAIT) && (state_n == S_WAIT))
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      resp_v_q <= done | tmo;
      resp_e_q <= tmo;
      rdata_q  <= (done & ~we_q) ? rd_ext : '0;
    end
  end

endmodule

// File: tb/tb_mm_reg_initiator.sv
// Directed bench for mm_reg_initiator (TIMEOUT_CYCLES = 8).
// Drives requests and a scripted WB responder, checks every output.
module tb_mm_reg_initiator;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic        rd_stb;
  logic [15:0] rd_adr;
  logic [31:0] rd_dat;
  logic        rd_ack;
  logic        wr_stb;
  logic        wr_we;
  logic [3:0]  wr_sel;
  logic [15:0] wr_adr;
  logic [31:0] wr_dat;
  logic        wr_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mm_reg_initiator #(
    .ADDR_BITS      (16),
    .XLEN           (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_error   (resp_error),
    .resp_rdata   (resp_rdata),
    .WB_RD_STB_O  (rd_stb),
    .WB_RD_ADR_O  (rd_adr),
    .WB_RD_DAT_I  (rd_dat),
    .WB_RD_ACK_I  (rd_ack),
    .WB_WR_STB_O  (wr_stb),
    .WB_WR_WE_O   (wr_we),
    .WB_WR_SEL_O  (wr_sel),
    .WB_WR_ADR_O  (wr_adr),
    .WB_WR_DAT_O  (wr_dat),
    .WB_WR_ACK_I  (wr_ack)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        we,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        uns,
    input logic [31:0] wdata
  );
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
  endtask

  task automatic idle_req();
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
  endtask

  task automatic run_req(
    input string       tag,
    input logic        we,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        uns,
    input logic [31:0] wdata,
    input logic [31:0] bus,
    input logic [15:0] e_adr,
    input logic [3:0]  e_sel,
    input logic [31:0] e_dat,
    input logic [31:0] e_rd
  );
    drive(we, addr, size, uns, wdata);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    step();
    idle_req();
    check({tag, ".rd_stb"}, {31'd0, rd_stb}, {31'd0, ~we});
    check({tag, ".wr_stb"}, {31'd0, wr_stb}, {31'd0, we});
    check({tag, ".wr_we"}, {31'd0, wr_we}, {31'd0, we});
    if (we) begin
      check({tag, ".adr"}, {16'd0, wr_adr}, {16'd0, e_adr});
      check({tag, ".sel"}, {28'd0, wr_sel}, {28'd0, e_sel});
      check({tag, ".dat"}, wr_dat, e_dat);
    end else begin
      check({tag, ".adr"}, {16'd0, rd_adr}, {16'd0, e_adr});
    end
    step();
    check({tag, ".stb_pulse"}, {30'd0, rd_stb, wr_stb}, 32'd0);
    check({tag, ".early"}, {31'd0, resp_valid}, 32'd0);
    if (we) wr_ack = 1'b1;
    else    rd_ack = 1'b1;
    rd_dat = bus;
    step();
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    rd_dat = '0;
    check({tag, ".rvalid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".rerr"}, {31'd0, resp_error}, 32'd0);
    check({tag, ".rdata"}, resp_rdata, e_rd);
    check({tag, ".ready2"}, {31'd0, req_ready}, 32'd1);
    step();
    check({tag, ".rpulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic run_err(
    input string       tag,
    input logic        we,
    input logic [31:0] addr,
    input logic [1:0]  size
  );
    drive(we, addr, size, 1'b0, 32'hFFFF_FFFF);
    step();
    idle_req();
    check({tag, ".stb"}, {30'd0, rd_stb, wr_stb}, 32'd0);
    check({tag, ".rvalid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".rerr"}, {31'd0, resp_error}, 32'd1);
    check({tag, ".rdata"}, resp_rdata, 32'd0);
    step();
    check({tag, ".rpulse"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".stb"}, {29'd0, rd_stb, wr_stb, wr_we}, 32'd0);
    check({tag, ".sel"}, {28'd0, wr_sel}, 32'd0);
    check({tag, ".adr"}, {rd_adr, wr_adr}, 32'd0);
    check({tag, ".dat"}, wr_dat, 32'd0);
    check({tag, ".resp"}, {30'd0, resp_valid, resp_error}, 32'd0);
    check({tag, ".rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    sync_reset = 1'b1;
    rd_ack     = 1'b0;
    wr_ack     = 1'b0;
    rd_dat     = '0;
    idle_req();
    step();
    step();
    check("rst.ready", {31'd0, req_ready}, 32'd0);
    check_quiet("rst");
    sync_reset = 1'b0;
    #1;
    check("rst.ready_rel", {31'd0, req_ready}, 32'd1);
    step();

    run_req("st_w", 1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,
            16'h008, 4'hF, 32'hDEAD_BEEF, 32'h0);
    run_req("st_b", 1'b1, 32'h23, 2'd0, 1'b0, 32'h0000_00A5, 32'h0,
            16'h008, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    run_req("st_h", 1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_1234, 32'h0,
            16'h008, 4'b1100, 32'h1234_1234, 32'h0);
    run_req("ld_hs", 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 32'h8001_7FFF,
            16'h004, 4'h0, 32'h0, 32'hFFFF_8001);
    run_req("ld_hu", 1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 32'h8001_7FFF,
            16'h004, 4'h0, 32'h0, 32'h0000_8001);
    run_req("ld_bu", 1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 32'h8001_7FFF,
            16'h004, 4'h0, 32'h0, 32'h0000_007F);
    run_req("ld_bs", 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 32'h8001_7FFF,
            16'h004, 4'h0, 32'h0, 32'hFFFF_FF80);

    run_err("err_w", 1'b0, 32'h22, 2'd2);
    run_err("err_sz", 1'b1, 32'h20, 2'd3);
    run_err("err_h", 1'b0, 32'h11, 2'd1);

    drive(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    step();
    idle_req();
    for (int i = 0; i < 9; i++) begin
      check("tmo.wait", {31'd0, resp_valid}, 32'd0);
      step();
    end
    check("tmo.rvalid", {31'd0, resp_valid}, 32'd1);
    check("tmo.rerr", {31'd0, resp_error}, 32'd1);
    check("tmo.rdata", resp_rdata, 32'd0);
    step();
    step();
    step();
    rd_ack = 1'b1;
    rd_dat = 32'hFFFF_FFFF;
    step();
    rd_ack = 1'b0;
    rd_dat = '0;
    check("tmo.late_ack", {31'd0, resp_valid}, 32'd0);
    check("tmo.ready", {31'd0, req_ready}, 32'd1);
    run_req("tmo.next", 1'b0, 32'h24, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D,
            16'h009, 4'h0, 32'h0, 32'hCAFE_F00D);

    drive(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
    step();
    idle_req();
    step();
    step();
    sync_reset = 1'b1;
    #1;
    check("abort.ready", {31'd0, req_ready}, 32'd0);
    step();
    sync_reset = 1'b0;
    check_quiet("abort");
    rd_ack = 1'b1;
    rd_dat = 32'hFFFF_FFFF;
    step();
    rd_ack = 1'b0;
    rd_dat = '0;
    check("abort.stale", {31'd0, resp_valid}, 32'd0);
    run_req("abort.next", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h1234_5678,
            16'h010, 4'h0, 32'h0, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
